// File: rtl/iq_phase_detector.sv
// iq_phase_detector: per-channel I/Q correlator with one shared CORDIC
// vectoring solver that reports phase (0.01 deg units) and normalised magnitude.
module iq_phase_detector #(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 2,
    parameter int LOG2_N      = 10,
    parameter int CORDIC_ITER = 14
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           in_valid,
    input  logic [NUM_CH*DATA_W-1:0]                       signal,
    input  logic [DATA_W-1:0]                              ref_sig,
    input  logic [DATA_W-1:0]                              ref_sig_q,
    output logic signed [15:0]                             phase_out,
    output logic [DATA_W:0]                                mag_out,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] phase_ch,
    output logic                                           phase_valid,
    input  logic                                           phase_ready,
    output logic                                           overrun
);

    localparam int PW    = 2 * DATA_W;
    localparam int AW    = PW + LOG2_N;
    localparam int CW    = AW + 2;
    localparam int ZW    = 26;
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ITW   = (CORDIC_ITER > 1) ? $clog2(CORDIC_ITER) : 1;
    localparam int MPW   = CW + 17;
    localparam int SH    = 16 + LOG2_N + DATA_W - 1;
    localparam int MAGK  = 39797;
    localparam logic [DATA_W:0] MAGMAX = '1;
    localparam logic [CHW-1:0]  LASTCH = CHW'(NUM_CH - 1);
    localparam logic [ITW-1:0]  LASTIT = ITW'(CORDIC_ITER - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROT   = 3'd2;
    localparam logic [2:0] S_SCALE = 3'd3;
    localparam logic [2:0] S_PRES  = 3'd4;

    // atan(2^-i) in 1/256 of 0.01 degree
    function automatic logic signed [ZW-1:0] f_atan(input logic [ITW-1:0] i);
        logic signed [ZW-1:0] v;
        v = '0;
        case (int'(i))
            0:  v = ZW'(1152000);
            1:  v = ZW'(680065);
            2:  v = ZW'(359328);
            3:  v = ZW'(182400);
            4:  v = ZW'(91554);
            5:  v = ZW'(45822);
            6:  v = ZW'(22916);
            7:  v = ZW'(11459);
            8:  v = ZW'(5730);
            9:  v = ZW'(2865);
            10: v = ZW'(1432);
            11: v = ZW'(716);
            12: v = ZW'(358);
            13: v = ZW'(179);
            14: v = ZW'(90);
            15: v = ZW'(45);
            default: v = '0;
        endcase
        return v;
    endfunction

    logic signed [AW-1:0] r_iacc [NUM_CH];
    logic signed [AW-1:0] r_qacc [NUM_CH];
    logic signed [AW-1:0] r_bi   [NUM_CH];
    logic signed [AW-1:0] r_bq   [NUM_CH];
    logic signed [PW-1:0] w_prod_i [NUM_CH];
    logic signed [PW-1:0] w_prod_q [NUM_CH];
    logic signed [AW-1:0] w_sum_i  [NUM_CH];
    logic signed [AW-1:0] w_sum_q  [NUM_CH];
    logic signed [PW-1:0] w_ri, w_rq, w_s;

    logic [LOG2_N-1:0]    r_cnt;
    logic [2:0]           r_state;
    logic [CHW-1:0]       r_ch;
    logic [ITW-1:0]       r_iter;
    logic signed [CW-1:0] r_x, r_y;
    logic signed [ZW-1:0] r_z;
    logic                 r_zero;
    logic signed [15:0]   r_phase;
    logic [DATA_W:0]      r_mag;
    logic                 r_valid;
    logic                 r_ovr;

    logic                 w_last, w_snap_ok;
    logic signed [AW-1:0] w_bi, w_bq;
    logic signed [CW-1:0] w_xi, w_yi, w_xs, w_ys;
    logic signed [ZW-1:0] w_zr;
    logic signed [15:0]   w_ph;
    logic [MPW-1:0]       w_mp, w_mr;
    logic [DATA_W:0]      w_mag;

    always_comb begin
        w_ri = {{DATA_W{ref_sig[DATA_W-1]}}, ref_sig};
        w_rq = {{DATA_W{ref_sig_q[DATA_W-1]}}, ref_sig_q};
        w_s  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_s = {{DATA_W{signal[k*DATA_W+DATA_W-1]}}, signal[k*DATA_W +: DATA_W]};
            w_prod_i[k] = w_s * w_ri;
            w_prod_q[k] = w_s * w_rq;
            w_sum_i[k]  = r_iacc[k] + {{LOG2_N{w_prod_i[k][PW-1]}}, w_prod_i[k]};
            w_sum_q[k]  = r_qacc[k] + {{LOG2_N{w_prod_q[k][PW-1]}}, w_prod_q[k]};
        end
    end

    assign w_last    = in_valid && (r_cnt == '1);
    // a snapshot may land on the same edge that hands off the last channel
    assign w_snap_ok = (r_state == S_IDLE) ||
                       (r_state == S_PRES && phase_ready && r_ch == LASTCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_iacc[k] <= '0;
                r_qacc[k] <= '0;
                r_bi[k]   <= '0;
                r_bq[k]   <= '0;
            end
        end else if (in_valid) begin
            r_cnt <= r_cnt + LOG2_N'(1);
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_last) begin
                    r_iacc[k] <= '0;
                    r_qacc[k] <= '0;
                    if (w_snap_ok) begin
                        r_bi[k] <= w_sum_i[k];
                        r_bq[k] <= w_sum_q[k];
                    end
                end else begin
                    r_iacc[k] <= w_sum_i[k];
                    r_qacc[k] <= w_sum_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_ovr <= 1'b0;
        else if (w_last && !w_snap_ok)
            r_ovr <= 1'b1;
    end

    assign w_bi = r_bi[r_ch];
    assign w_bq = r_bq[r_ch];
    assign w_xi = {{2{w_bi[AW-1]}}, w_bi};
    assign w_yi = {{2{w_bq[AW-1]}}, w_bq};
    assign w_xs = r_x >>> r_iter;
    assign w_ys = r_y >>> r_iter;

    assign w_zr  = (r_z + ZW'(128)) >>> 8;
    assign w_ph  = 16'((w_zr >= ZW'(18000)) ? w_zr - ZW'(36000) : w_zr);
    assign w_mp  = MPW'($unsigned(r_x)) * MPW'(MAGK);
    assign w_mr  = (w_mp + (MPW'(1) << (SH - 1))) >> SH;
    assign w_mag = (w_mr > MPW'(MAGMAX)) ? MAGMAX : w_mr[DATA_W:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_phase <= '0;
            r_mag   <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_last) begin
                        r_state <= S_LOAD;
                        r_ch    <= '0;
                    end
                end
                S_LOAD: begin
                    // left half-plane: rotate by 180 deg so vectoring converges
                    r_x     <= w_bi[AW-1] ? -w_xi : w_xi;
                    r_y     <= w_bi[AW-1] ? -w_yi : w_yi;
                    r_z     <= w_bi[AW-1] ? ZW'(4608000) : '0;
                    r_zero  <= (w_bi == '0) && (w_bq == '0);
                    r_iter  <= '0;
                    r_state <= S_ROT;
                end
                S_ROT: begin
                    if (r_y[CW-1]) begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - f_atan(r_iter);
                    end else begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + f_atan(r_iter);
                    end
                    r_iter <= r_iter + ITW'(1);
                    if (r_iter == LASTIT)
                        r_state <= S_SCALE;
                end
                S_SCALE: begin
                    r_phase <= r_zero ? '0 : w_ph;
                    r_mag   <= r_zero ? '0 : w_mag;
                    r_valid <= 1'b1;
                    r_state <= S_PRES;
                end
                S_PRES: begin
                    if (phase_ready) begin
                        r_valid <= 1'b0;
                        if (r_ch == LASTCH) begin
                            r_ch    <= '0;
                            r_state <= w_last ? S_LOAD : S_IDLE;
                        end else begin
                            r_ch    <= r_ch + CHW'(1);
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign phase_out   = r_phase;
    assign mag_out     = r_mag;
    assign phase_ch    = r_ch;
    assign phase_valid = r_valid;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_iq_phase_detector.sv
// tb_iq_phase_detector: scoreboard bench; a real-valued model predicts each
// block's per-channel phase/magnitude and results are matched on transfer.
module tb_iq_phase_detector;

    localparam int DW  = 12;
    localparam int NCH = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic [NCH*DW-1:0]     signal;
    logic [DW-1:0]         ref_sig;
    logic [DW-1:0]         ref_sig_q;
    logic signed [15:0]    phase_out;
    logic [DW:0]           mag_out;
    logic [0:0]            phase_ch;
    logic                  phase_valid;
    logic                  phase_ready;
    logic                  overrun;

    always #5 clk = ~clk;

    iq_phase_detector dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .signal     (signal),
        .ref_sig    (ref_sig),
        .ref_sig_q  (ref_sig_q),
        .phase_out  (phase_out),
        .mag_out    (mag_out),
        .phase_ch   (phase_ch),
        .phase_valid(phase_valid),
        .phase_ready(phase_ready),
        .overrun    (overrun)
    );

    typedef struct {
        int ch;
        int ph;
        int ptol;
        int mag;
        int mtol;
    } exp_t;

    exp_t   sb[$];
    int     errs = 0;
    int     checks = 0;
    longint mi[NCH];
    longint mq[NCH];
    int     cnt = 0;
    int     idx = 0;
    int     mode = 0;
    int     cyc = 0;
    int     nxfer = 0;
    int     snap_cyc = -1;
    int     c8[8] = '{2047, 1447, 0, -1447, -2047, -1447, 0, 1447};
    int     s8[8] = '{0, 1447, 2047, 1447, 0, -1447, -2047, -1447};

    task automatic check(input string tag, input longint got,
                         input longint exp, input longint tol,
                         input longint wrap);
        longint d;
        checks++;
        d = got - exp;
        if (wrap != 0) begin
            while (d > wrap / 2) d -= wrap;
            while (d < -wrap / 2) d += wrap;
        end
        if (d < 0) d = -d;
        if (d > tol) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int chv(input int k, input int c, input int s);
        if (mode == 0) return (k == 0) ? c : s;
        if (mode == 1) return (k == 0) ? (c + s) / 2 : -c;
        return 0;
    endfunction

    task automatic push_block();
        exp_t e;
        real  fi, fq, ph, m;
        for (int k = 0; k < NCH; k++) begin
            fi = real'(mi[k]);
            fq = real'(mq[k]);
            ph = $atan2(fq, fi) * 18000.0 / 3.141592653589793;
            m  = $sqrt(fi * fi + fq * fq) / 2097152.0;
            e.ch   = k;
            e.ph   = int'(ph);
            if (e.ph >= 18000) e.ph -= 36000;
            e.ptol = 10;
            e.mag  = int'(m);
            if (e.mag > 4095) e.mag = 4095;
            e.mtol = int'(m / 100.0);
            if (e.mtol < 1) e.mtol = 1;
            if (mi[k] == 0 && mq[k] == 0) begin
                e.ph = 0; e.ptol = 0; e.mag = 0; e.mtol = 0;
            end
            sb.push_back(e);
        end
    endtask

    // called at a falling edge; drives one cycle and advances to the next
    task automatic step(input bit v, input bit rdy, input bit rst = 1'b0);
        int   c, s;
        exp_t e;
        c = c8[idx % 8];
        s = s8[idx % 8];
        reset       = rst;
        in_valid    = v;
        phase_ready = rdy;
        ref_sig     = DW'(c);
        ref_sig_q   = DW'(s);
        for (int k = 0; k < NCH; k++)
            signal[k*DW +: DW] = DW'(chv(k, c, s));
        if (!rst) begin
            if (phase_valid && sb.size() == 0)
                check("spurious_valid", 1, 0, 0, 0);
            if (phase_valid && sb.size() > 0) begin
                e = sb[0];
                if (snap_cyc >= 0) begin
                    check("latency", cyc - snap_cyc, 10, 9, 0);
                    snap_cyc = -1;
                end
                if (rdy || (cyc % 256 == 0)) begin
                    check("phase_ch", phase_ch, e.ch, 0, 0);
                    check("phase", phase_out, e.ph, e.ptol, 36000);
                    check("mag", mag_out, e.mag, e.mtol, 0);
                end
                if (rdy) begin
                    void'(sb.pop_front());
                    nxfer++;
                end
            end
            if (v) begin
                for (int k = 0; k < NCH; k++) begin
                    mi[k] += longint'(chv(k, c, s)) * c;
                    mq[k] += longint'(chv(k, c, s)) * s;
                end
                idx++;
                cnt++;
                if (cnt == 1024) begin
                    cnt = 0;
                    if (sb.size() == 0) begin
                        push_block();
                        snap_cyc = cyc;
                    end
                    for (int k = 0; k < NCH; k++) begin
                        mi[k] = 0;
                        mq[k] = 0;
                    end
                end
            end
        end else begin
            sb.delete();
            cnt = 0;
            snap_cyc = -1;
            for (int k = 0; k < NCH; k++) begin
                mi[k] = 0;
                mq[k] = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic feed(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, rdy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("drain", sb.size(), 0, 0, 0);
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_phase"}, phase_out, 0, 0, 0);
        check({tag, "_mag"}, mag_out, 0, 0, 0);
        check({tag, "_ch"}, phase_ch, 0, 0, 0);
        check({tag, "_valid"}, phase_valid, 0, 0, 0);
        check({tag, "_ovr"}, overrun, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  acc, n;
        bit  t, done;
        reset       = 1'b1;
        in_valid    = 1'b0;
        phase_ready = 1'b1;
        signal      = '0;
        ref_sig     = '0;
        ref_sig_q   = '0;
        for (int k = 0; k < NCH; k++) begin
            mi[k] = 0;
            mq[k] = 0;
        end
        @(negedge clk);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_zero_outs("reset");

        mode = 0;
        feed(1024, 1'b1);
        drain();

        mode = 1;
        feed(1024, 1'b1);
        drain();

        mode = 2;
        feed(1024, 1'b1);
        drain();
        check("zero_ovr", overrun, 0, 0, 0);

        mode = 0;
        acc = 0;
        t = 1'b0;
        while (acc < 1024) begin
            step(t, 1'b1);
            if (t) acc++;
            t = ~t;
        end
        drain();

        // last-channel handoff coinciding with the next snapshot
        mode = 1;
        feed(1024, 1'b0);
        feed(1023, 1'b0);
        done = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            if (phase_valid && sb.size() == 1) begin
                step(1'b1, 1'b1);
                done = 1'b1;
            end else begin
                step(1'b0, 1'b1);
            end
            n++;
        end
        check("coinc_reached", done, 1, 0, 0);
        drain();
        check("coinc_ovr", overrun, 0, 0, 0);

        mode = 0;
        for (int i = 0; i < 3000; i++) step(i < 2048, 1'b0);
        check("ovr_set", overrun, 1, 0, 0);
        nxfer = 0;
        drain();
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1);
        check("held_xfers", nxfer, NCH, 0, 0);
        check("ovr_sticky", overrun, 1, 0, 0);

        mode = 1;
        feed(1024, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_zero_outs("abort");
        feed(1023, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        check("abort_quiet", phase_valid, 0, 0, 0);
        feed(1, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/iq_phase_detector.md
IQ_PHASE_DETECTOR -- requirements
Module: iq_phase_detector

Interface
REQ-001 SHALL have parameter DATA_W, default 12: signed two's-complement sample width of signal and references.
REQ-002 SHALL have parameter NUM_CH, default 2: number of signal channels sharing one reference pair.
REQ-003 SHALL have parameter LOG2_N, default 10: integration block length of 2^LOG2_N accepted samples.
REQ-004 SHALL have parameter CORDIC_ITER, default 14: number of CORDIC vectoring iterations.
REQ-005 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous, active-high), listed first.
REQ-006 SHALL have port in_valid (in, 1): the current signal/ref_sig/ref_sig_q sample is accepted.
REQ-007 SHALL have port signal (in, NUM_CH*DATA_W): channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have ports ref_sig (in, DATA_W, in-phase reference) and ref_sig_q (in, DATA_W, quadrature reference).
REQ-009 SHALL have port phase_out (out, 16, signed): atan2(Q,I) in 0.01 degree units, range -18000..17999.
REQ-010 SHALL have port mag_out (out, DATA_W+1, unsigned): normalised magnitude.
REQ-011 SHALL have port phase_ch (out, max(1,clog2(NUM_CH))): channel index of the presented result.
REQ-012 SHALL have ports phase_valid (out, 1) and phase_ready (in, 1): result handshake.
REQ-013 SHALL have port overrun (out, 1): sticky flag for a dropped block.

Function
REQ-014 SHALL, per accepted sample and channel k, add signal_k*ref_sig to I_acc[k] and signal_k*ref_sig_q to Q_acc[k]; products are 2*DATA_W bits signed; accumulators are 2*DATA_W+LOG2_N bits and never overflow.
REQ-015 SHALL hold accumulators and sample counter unchanged while in_valid=0.
REQ-016 SHALL count accepted samples 0..2^LOG2_N-1 and wrap to 0; on the sample with count=2^LOG2_N-1, it SHALL snapshot all sums including that sample into a result buffer; the next accepted sample SHALL start from zero sums.
REQ-017 SHALL run solver FSM IDLE -> LOAD -> ROTATE (CORDIC_ITER cycles) -> SCALE -> PRESENT, then LOAD for the next channel, or IDLE after channel NUM_CH-1.
REQ-018 SHALL leave IDLE only on a snapshot; channels are processed in ascending order, 0 first.
REQ-019 SHALL pre-rotate inputs with I<0 by 180 degrees before vectoring, so the full four-quadrant range is covered.
REQ-020 SHALL report phase_out within +/-10 LSB of the ideal rounded atan2(Q,I)*100/pi*180; a result of +18000 or greater SHALL wrap to -18000.
REQ-021 SHALL compute mag_out = round(sqrt(I^2+Q^2) / 2^(LOG2_N+DATA_W-1)) within 1 percent (minimum +/-1 LSB), with CORDIC gain compensated and saturation at 2^(DATA_W+1)-1.
REQ-022 SHALL output phase_out=0 and mag_out=0 for a channel with I=Q=0.
REQ-023 SHALL assert phase_valid in PRESENT and hold phase_out/mag_out/phase_ch stable until the cycle with phase_valid and phase_ready both high (transfer).
REQ-024 SHALL assert phase_valid for channel 0 no more than CORDIC_ITER+4 cycles after the snapshot cycle, given phase_ready=1.
REQ-025 SHALL, when a snapshot occurs while the solver is not IDLE, discard the new snapshot and set overrun=1; accumulation continues unaffected.
REQ-026 SHALL accept a snapshot without overrun when it coincides with the transfer of channel NUM_CH-1.
REQ-027 SHALL clear overrun only by reset.

Reset
REQ-028 SHALL, on the clock edge with reset=1, clear accumulators, sample counter, result buffer and FSM (to IDLE), and set phase_out=0, mag_out=0, phase_ch=0, phase_valid=0 and overrun=0.
REQ-029 SHALL abort any in-progress solve on reset and produce no result until a full 2^LOG2_N-sample block has been accepted after reset deasserts.

Verification
REQ-030 Defaults, in_valid=1, 8-sample-period references of amplitude 2047, ch0=ref_sig, ch1=ref_sig_q -> ch0 phase 0+/-10 and mag 1023+/-10; ch1 phase 9000+/-10 and mag 1023+/-10; results in order ch0 then ch1.
REQ-031 ch0=(ref_sig+ref_sig_q)/2, ch1=-ref_sig -> ch0 phase 4500+/-10 and mag about 723; ch1 phase within -18000..-17990 or 17990..17999.
REQ-032 signal all zero -> phase_out=0 and mag_out=0 for every channel; overrun stays 0.
REQ-033 phase_ready=0 for 3000 cycles -> first ch0 result held stable; the second block sets overrun=1; after phase_ready=1, exactly NUM_CH results from block 1 are transferred.
REQ-034 in_valid toggled 50 percent -> same results as REQ-030, with the snapshot after 1024 accepted samples, not 1024 cycles.
REQ-035 reset pulsed during ROTATE -> next cycle all outputs are 0 and phase_valid=0; the first new result appears only after 1024 further accepted samples.
